mul_div_unit: RTL and testbench

Multiply/divide unit for the EX stage of the P6 pipeline. It produces the HI/LO value that the EX/MEM pipeline register latches on its `in_HI_LO` input. It executes mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency. While an operation runs it asserts `out_busy`, which the hazard unit uses to stall any later HI/LO-touching instruction in ID.

---
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div with architectural HI/LO
// and a registered busy flag for the ID-stage hazard logic.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_start,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic        in_rd_hi,
    output logic        out_busy,
    output logic [31:0] out_HI,
    output logic [31:0] out_LO,
    output logic [31:0] out_HI_LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    state_t            state, state_next;
    op_t               op;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hi, lo, tmp_hi, tmp_lo;

    logic              is_mul, is_div, is_signed, b_nonzero, accept_run;
    logic [63:0]       prod;
    logic [31:0]       a_mag, b_mag, b_safe, quot_mag, rem_mag, quot, rem;

    assign op        = op_t'(in_op);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign b_nonzero = (in_B != '0);
    assign accept_run = in_start && (is_mul || (is_div && b_nonzero));
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both mult forms.
    always_comb begin
        if (is_signed)
            prod = {{32{in_A[31]}}, in_A} * {{32{in_B[31]}}, in_B};
        else
            prod = {32'b0, in_A} * {32'b0, in_B};
    end

    // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_mag    = (is_signed && in_A[31]) ? (32'd0 - in_A) : in_A;
        b_mag    = (is_signed && in_B[31]) ? (32'd0 - in_B) : in_B;
        b_safe   = (b_mag == '0) ? 32'd1 : b_mag;
        quot_mag = a_mag / b_safe;
        rem_mag  = a_mag % b_safe;
        quot     = (is_signed && (in_A[31] ^ in_B[31])) ? (32'd0 - quot_mag) : quot_mag;
        rem      = (is_signed && in_A[31]) ? (32'd0 - rem_mag) : rem_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_run) state_next = RUN;
            RUN:  if (cnt == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_busy  = (state == RUN);
        out_HI    = hi;
        out_LO    = lo;
        out_HI_LO = in_rd_hi ? hi : lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
        end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi <= tmp_hi;
                lo <= tmp_lo;
            end
        end else if (in_start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    tmp_hi <= prod[63:32];
                    tmp_lo <= prod[31:0];
                    cnt    <= CNT_W'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    if (b_nonzero) begin
                        tmp_hi <= rem;
                        tmp_lo <= quot;
                        cnt    <= CNT_W'(DIV_CYCLES);
                    end
                end
                OP_MTHI: hi <= in_A;
                OP_MTLO: lo <= in_A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, ignored
// requests during RUN, divide-by-zero and asynchronous reset mid-operation.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_start = 1'b0;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_A = '0;
    logic [31:0] in_B = '0;
    logic        in_rd_hi = 1'b0;
    logic        out_busy;
    logic [31:0] out_HI, out_LO, out_HI_LO;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                           DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_start  (in_start),
        .in_op     (in_op),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_rd_hi  (in_rd_hi),
        .out_busy  (out_busy),
        .out_HI    (out_HI),
        .out_LO    (out_LO),
        .out_HI_LO (out_HI_LO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse a request for one edge, then count busy cycles (bounded) until idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned exp_busy);
        int unsigned cycles;
        @(negedge clk);
        in_start = 1'b1; in_op = op; in_A = a; in_B = b;
        @(negedge clk);
        in_start = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!out_busy) break;
            cycles++;
            @(negedge clk);
        end
        check_eq({tag, " busy"}, cycles, exp_busy);
    endtask

    initial begin
        int unsigned waited;

        repeat (2) @(negedge clk);
        check_eq("rst busy", {31'b0, out_busy}, 32'd0);
        check_eq("rst HI", out_HI, 32'd0);
        check_eq("rst LO", out_LO, 32'd0);
        check_eq("rst HI_LO", out_HI_LO, 32'd0);
        reset = 1'b0;

        run_op("mult", MULT, 32'hFFFFFFFD, 32'd5, 5);
        check_eq("mult HI", out_HI, 32'hFFFFFFFF);
        check_eq("mult LO", out_LO, 32'hFFFFFFF1);
        in_rd_hi = 1'b0; #1;
        check_eq("mult HI_LO lo", out_HI_LO, 32'hFFFFFFF1);

        run_op("multu", MULTU, 32'hFFFFFFFF, 32'd2, 5);
        check_eq("multu HI", out_HI, 32'h00000001);
        check_eq("multu LO", out_LO, 32'hFFFFFFFE);
        in_rd_hi = 1'b1; #1;
        check_eq("multu HI_LO hi", out_HI_LO, 32'h00000001);
        in_rd_hi = 1'b0; #1;
        check_eq("multu HI_LO lo", out_HI_LO, 32'hFFFFFFFE);

        run_op("mult min", MULT, 32'h80000000, 32'h80000000, 5);
        check_eq("mult min HI", out_HI, 32'h40000000);
        check_eq("mult min LO", out_LO, 32'h00000000);

        run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 10);
        check_eq("div LO", out_LO, 32'hFFFFFFFD);
        check_eq("div HI", out_HI, 32'hFFFFFFFF);

        run_op("div negB", DIV, 32'd7, 32'hFFFFFFFE, 10);
        check_eq("div negB LO", out_LO, 32'hFFFFFFFD);
        check_eq("div negB HI", out_HI, 32'h00000001);

        run_op("divu", DIVU, 32'd7, 32'd2, 10);
        check_eq("divu LO", out_LO, 32'd3);
        check_eq("divu HI", out_HI, 32'd1);

        run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 10);
        check_eq("div ovf LO", out_LO, 32'h80000000);
        check_eq("div ovf HI", out_HI, 32'h00000000);

        run_op("mtlo", MTLO, 32'h12345678, 32'd0, 0);
        check_eq("mtlo LO", out_LO, 32'h12345678);
        check_eq("mtlo HI", out_HI, 32'h00000000);
        run_op("divu by0", DIVU, 32'd7, 32'd0, 0);
        check_eq("divu by0 LO", out_LO, 32'h12345678);
        check_eq("divu by0 HI", out_HI, 32'h00000000);

        run_op("nop op", 3'b111, 32'hDEADBEEF, 32'd1, 0);
        check_eq("nop LO", out_LO, 32'h12345678);

        // mult 3x4 with an mthi arriving while busy: must be dropped
        @(negedge clk);
        in_start = 1'b1; in_op = MULT; in_A = 32'd3; in_B = 32'd4;
        @(negedge clk);
        in_start = 1'b0;
        check_eq("mult34 busy c1", {31'b0, out_busy}, 32'd1);
        @(negedge clk);
        in_start = 1'b1; in_op = MTHI; in_A = 32'hAAAA0000;
        @(negedge clk);
        in_start = 1'b0;
        waited = 0;
        while (out_busy && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        check_eq("mult34 busy c>2", waited, 32'd3);
        check_eq("mult34 HI", out_HI, 32'd0);
        check_eq("mult34 LO", out_LO, 32'd12);
        run_op("mthi", MTHI, 32'hAAAA0000, 32'd0, 0);
        check_eq("mthi HI", out_HI, 32'hAAAA0000);
        check_eq("mthi LO", out_LO, 32'd12);

        // asynchronous reset during a div
        @(negedge clk);
        in_start = 1'b1; in_op = DIV; in_A = 32'd100; in_B = 32'd7;
        @(negedge clk);
        in_start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("div4 busy", {31'b0, out_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst busy", {31'b0, out_busy}, 32'd0);
        check_eq("arst HI", out_HI, 32'd0);
        check_eq("arst LO", out_LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("post arst busy", {31'b0, out_busy}, 32'd0);
        check_eq("post arst HI", out_HI, 32'd0);
        check_eq("post arst LO", out_LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
